hv_wdg_reg_scan_ctrl: RTL

//  Periodic watchdog register-integrity scanner; the requester behind the wdg_scan port of the

---
 rtl/hv_wdg_reg_scan_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/hv_wdg_reg_scan_ctrl.sv
// hv_wdg_reg_scan_ctrl
// Periodic watchdog register-integrity scanner. After an idle gap it walks an address
// window, issuing one held read per address. Each returned word is checked against a
// locally computed CRC-8, and a read whose ack does not arrive in time counts as a timeout.
// Both kinds of error produce a one-cycle pulse, set a sticky fail flag and increment a
// saturating error counter.
module hv_wdg_reg_scan_ctrl #(
    parameter int AW          = 7,
    parameter int DW          = 8,
    parameter int CRC_W       = 8,
    parameter int PERIOD_CYC  = 1024,
    parameter int TIMEOUT_CYC = 64,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scan_en,
    input  logic [AW-1:0]        i_scan_start_addr,
    input  logic [AW-1:0]        i_scan_end_addr,
    input  logic                 i_err_clr,
    output logic                 o_wdg_scan_rac_rd_req,
    output logic [AW-1:0]        o_wdg_scan_rac_addr,
    input  logic                 i_rac_wdg_scan_ack,
    input  logic [DW-1:0]        i_rac_wdg_scan_data,
    input  logic [CRC_W-1:0]     i_rac_wdg_scan_crc,
    output logic                 o_scan_busy,
    output logic                 o_scan_done,
    output logic                 o_scan_err,
    output logic                 o_scan_err_type,
    output logic [AW-1:0]        o_scan_err_addr,
    output logic                 o_scan_fail,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int GAP_W = $clog2(PERIOD_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(PERIOD_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CRC_W-1:0] CRC_POLY = CRC_W'(8'h07);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_REQ  = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [AW-1:0]          end_q, end_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   err_type_q, err_type_d;
    logic [AW-1:0]          err_addr_q, err_addr_d;
    logic                   fail_q, fail_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                   ack_valid;
    logic                   crc_bad;
    logic                   timeout_hit;
    logic                   err_hit;

    // MSB-first CRC-8 shift register, zero initial value, no reflection or final xor.
    function automatic logic [CRC_W-1:0] crc_calc(input logic [DW-1:0] data);
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            fb  = crc[CRC_W-1] ^ data[i];
            crc = {crc[CRC_W-2:0], 1'b0};
            if (fb) begin
                crc = crc ^ CRC_POLY;
            end
        end
        return crc;
    endfunction

    // Acks are only meaningful while a read is outstanding; stale ones are dropped here.
    assign ack_valid   = (state_q == ST_REQ) && i_rac_wdg_scan_ack;
    assign crc_bad     = ack_valid && (crc_calc(i_rac_wdg_scan_data) != i_rac_wdg_scan_crc);
    // An ack arriving on the last allowed cycle still wins over the timeout.
    assign timeout_hit = (state_q == ST_REQ) && !i_rac_wdg_scan_ack && (to_cnt_q == TO_LAST);
    // Disabling the scanner suppresses any error decided in the same cycle.
    assign err_hit     = i_scan_en && (crc_bad || timeout_hit);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping the enable returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (!i_scan_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_GAP;
                ST_GAP:  if (gap_cnt_q == GAP_LAST) state_d = ST_REQ;
                ST_REQ:  if (ack_valid || timeout_hit) state_d = ST_NEXT;
                ST_NEXT: state_d = (addr_q == end_q) ? ST_GAP : ST_REQ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counters, window address and registered outputs for the next cycle.
    always_comb begin
        // Counters run only inside their own state, so they restart at zero on every entry.
        gap_cnt_d  = (i_scan_en && (state_q == ST_GAP)) ? gap_cnt_q + GAP_W'(1) : '0;
        to_cnt_d   = (i_scan_en && (state_q == ST_REQ) && !i_rac_wdg_scan_ack)
                     ? to_cnt_q + TO_W'(1) : '0;
        addr_d     = addr_q;
        end_d      = end_q;
        // Request follows the state by one cycle, so it stays up through NEXT after an ack.
        req_d      = i_scan_en && (state_q == ST_REQ);
        busy_d     = (state_d == ST_REQ) || (state_d == ST_NEXT);
        done_d     = (state_q == ST_NEXT) && (state_d == ST_GAP);
        err_d      = err_hit;
        err_type_d = err_type_q;
        err_addr_d = err_addr_q;
        fail_d     = fail_q;
        err_cnt_d  = err_cnt_q;

        if ((state_q == ST_GAP) && (state_d == ST_REQ)) begin
            // Window is sampled once per pass; an inverted window collapses to its start.
            addr_d = i_scan_start_addr;
            end_d  = (i_scan_end_addr < i_scan_start_addr) ? i_scan_start_addr : i_scan_end_addr;
        end else if ((state_q == ST_NEXT) && (state_d == ST_REQ)) begin
            addr_d = addr_q + AW'(1);
        end

        if (err_hit) begin
            err_type_d = timeout_hit;
            err_addr_d = addr_q;
        end

        // Clear beats a simultaneous error for the flag and counter, but not for the pulse.
        if (i_err_clr) begin
            fail_d    = 1'b0;
            err_cnt_d = '0;
        end else if (err_hit) begin
            fail_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
            addr_q     <= '0;
            end_q      <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_type_q <= 1'b0;
            err_addr_q <= '0;
            fail_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_type_q <= err_type_d;
            err_addr_q <= err_addr_d;
            fail_q     <= fail_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_wdg_scan_rac_rd_req = req_q;
    assign o_wdg_scan_rac_addr   = addr_q;
    assign o_scan_busy           = busy_q;
    assign o_scan_done           = done_q;
    assign o_scan_err            = err_q;
    assign o_scan_err_type       = err_type_q;
    assign o_scan_err_addr       = err_addr_q;
    assign o_scan_fail           = fail_q;
    assign o_err_cnt             = err_cnt_q;

endmodule
